// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-fetch-PC sequencer driving the I-cache and the BTB, throttled by instruction-buffer credits.
// Ports: clk, rst (sync, active-high); redirect_valid/redirect_pc; stall; credit_return;
//        pred_valid/pred_taken/pred_target (BTB answer, one cycle after btb_req);
//        fetch_req/fetch_pc/fetch_epoch to the cache; btb_req/btb_pc mirror the fetch.
// Optional macro FETCH_PERF_EN adds perf_taken_cnt and perf_redirect_cnt (32-bit, wrapping).
module fetch_pc_gen #(
    parameter int PC_W = 32,
    parameter int LINE_BYTES = 16,
    parameter int CREDITS = 4,
    parameter int EPOCH_W = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    input  logic               credit_return,
    input  logic               pred_valid,
    input  logic               pred_taken,
    input  logic [PC_W-1:0]    pred_target,
    output logic               fetch_req,
    output logic [PC_W-1:0]    fetch_pc,
    output logic [EPOCH_W-1:0] fetch_epoch,
    output logic               btb_req,
`ifdef FETCH_PERF_EN
    output logic [PC_W-1:0]    btb_pc,
    output logic [31:0]        perf_taken_cnt,
    output logic [31:0]        perf_redirect_cnt
`else
    output logic [PC_W-1:0]    btb_pc
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);
    localparam logic [PC_W-1:0] LINE = PC_W'(LINE_BYTES);
    state_t state;
    logic [PC_W-1:0] pc_r, cand, seq_pc;
    logic [3:0] credit_r, credit_nxt;
    logic [EPOCH_W-1:0] epoch_r;
    logic issued_r, take;
    // A prediction only belongs to us if we issued last cycle; a target is forwarded
    // straight into this cycle's fetch so a taken branch costs no bubble.
    always_comb begin
        take = issued_r & pred_valid & pred_taken;
        cand = take ? pred_target : pc_r;
        fetch_req = (state != BOOT) & ~redirect_valid & ~stall & (credit_r != 4'd0);
        seq_pc = (cand & ~(LINE - PC_W'(1))) + LINE;
        credit_nxt = (fetch_req & credit_return) ? credit_r :
                     fetch_req ? credit_r - 4'd1 :
                     (credit_return & (credit_r != CRED_MAX)) ? credit_r + 4'd1 : credit_r;
    end
    assign fetch_pc = cand;
    assign fetch_epoch = epoch_r;
    assign btb_req = fetch_req;
    assign btb_pc = cand;
    // A taken target that could not issue is latched into pc_r so it is fetched later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
            credit_r <= CRED_MAX;
            epoch_r <= '0;
            issued_r <= 1'b0;
            state <= BOOT;
        end else begin
            pc_r <= redirect_valid ? redirect_pc : fetch_req ? seq_pc : take ? pred_target : pc_r;
            credit_r <= credit_nxt;
            epoch_r <= epoch_r + EPOCH_W'(redirect_valid);
            issued_r <= fetch_req;
            state <= (state != BOOT && (credit_r == 4'd0 || stall)) ? HOLD : RUN;
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_taken_cnt <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            perf_taken_cnt <= perf_taken_cnt + 32'(take);
            perf_redirect_cnt <= perf_redirect_cnt + 32'(redirect_valid);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vector table plus randomized run against a reference model of fetch_pc_gen.
module tb_fetch_pc_gen;
    logic clk = 1'b0;
    logic rst, redirect_valid, stall, credit_return, pred_valid, pred_taken;
    logic [31:0] redirect_pc, pred_target, fetch_pc, btb_pc;
    logic fetch_req, btb_req;
    logic [1:0] fetch_epoch;
    always #5 clk = ~clk;
    fetch_pc_gen #(.PC_W(32), .LINE_BYTES(16), .CREDITS(4), .EPOCH_W(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .credit_return(credit_return), .pred_valid(pred_valid),
        .pred_taken(pred_taken), .pred_target(pred_target), .fetch_req(fetch_req),
        .fetch_pc(fetch_pc), .fetch_epoch(fetch_epoch), .btb_req(btb_req), .btb_pc(btb_pc)
    );
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic rst, rv;
        logic [31:0] rpc;
        logic st, cr, pv, pt;
        logic [31:0] tgt;
        logic req;
        logic [31:0] pc;
        logic [1:0] ep;
    } vec_t;
    vec_t tbl[$];
    longint m_pc;
    int m_cred, m_ep, m_since;
    bit m_iss, m_known = 0;
    function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic st, logic cr, logic pv,
                                logic pt, logic [31:0] tgt, logic req, logic [31:0] pc, logic [1:0] ep);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.st = st; v.cr = cr; v.pv = pv; v.pt = pt;
        v.tgt = tgt; v.req = req; v.pc = pc; v.ep = ep;
        return v;
    endfunction
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask
    function automatic void m_eval(output bit take, output bit req, output longint cand);
        take = m_iss && pred_valid && pred_taken;
        cand = take ? longint'(pred_target) : m_pc;
        req = m_since >= 1 && !redirect_valid && !stall && m_cred > 0;
    endfunction
    task automatic model_step();
        bit take, req;
        longint cand;
        if (rst) begin
            m_pc = 0; m_cred = 4; m_ep = 0; m_iss = 0; m_since = 0; m_known = 1;
        end else begin
            m_eval(take, req, cand);
            if (redirect_valid) m_pc = redirect_pc;
            else if (req) m_pc = ((cand / 16) * 16 + 16) % 64'h1_0000_0000;
            else if (take) m_pc = pred_target;
            if (req && !credit_return) m_cred--;
            else if (!req && credit_return && m_cred < 4) m_cred++;
            m_ep = (m_ep + int'(redirect_valid)) % 4;
            m_iss = req;
            m_since++;
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic idle_inputs();
        redirect_valid = 0; redirect_pc = 0; stall = 0; credit_return = 0;
        pred_valid = 0; pred_taken = 0; pred_target = 0;
    endtask
    initial begin
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h10,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h20,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h30,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,32'h40,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 0,32'h40,0));
        tbl.push_back(mk(0,1,32'h100,0,1,0,0,0, 0,32'h40,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 1,32'h100,1));
        tbl.push_back(mk(0,0,0,0,0,1,1,32'h2004, 1,32'h2004,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h2010,1));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 0,32'h2020,1));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 1,32'h2020,1));
        tbl.push_back(mk(0,1,32'h500,0,1,1,1,32'h900, 0,32'h900,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h500,2));
        tbl.push_back(mk(0,1,32'h40,0,0,0,0,0, 0,32'h510,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h40,3));
        tbl.push_back(mk(0,0,0,0,0,1,1,32'h800, 0,32'h800,3));
        tbl.push_back(mk(0,0,0,0,1,1,1,32'h999, 0,32'h800,3));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h800,3));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 0,32'h810,3));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 1,32'h810,3));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h820,3));
        tbl.push_back(mk(0,1,32'hFFFFFFF0,0,0,0,0,0, 0,32'h830,3));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 0,32'hFFFFFFF0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'hFFFFFFF0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,0, 0,32'h0,0));
        tbl.push_back(mk(0,0,0,1,1,0,0,0, 0,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h0,0));
        tbl.push_back(mk(0,1,32'h10,0,0,0,0,0, 0,32'h10,0));
        tbl.push_back(mk(0,1,32'h10,0,0,0,0,0, 0,32'h10,1));
        tbl.push_back(mk(0,1,32'h10,0,0,0,0,0, 0,32'h10,2));
        tbl.push_back(mk(0,1,32'h10,0,0,0,0,0, 0,32'h10,3));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h10,0));
        tbl.push_back(mk(0,1,32'h0,0,0,0,0,0, 0,32'h20,0));
        tbl.push_back(mk(0,1,32'h0,0,0,0,0,0, 0,32'h0,1));
        tbl.push_back(mk(0,0,0,1,0,0,0,0, 0,32'h0,2));
        tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,32'h0,2));
        tbl.push_back(mk(0,0,0,0,0,1,1,32'h700, 0,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h10,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,32'h20,0));
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            stall = tbl[i].st; credit_return = tbl[i].cr; pred_valid = tbl[i].pv;
            pred_taken = tbl[i].pt; pred_target = tbl[i].tgt;
            @(negedge clk);
            chk($sformatf("vec%0d fetch_req", i), 64'(fetch_req), 64'(tbl[i].req));
            chk($sformatf("vec%0d fetch_pc", i), 64'(fetch_pc), 64'(tbl[i].pc));
            chk($sformatf("vec%0d fetch_epoch", i), 64'(fetch_epoch), 64'(tbl[i].ep));
            chk($sformatf("vec%0d btb_req", i), 64'(btb_req), 64'(tbl[i].req));
            chk($sformatf("vec%0d btb_pc", i), 64'(btb_pc), 64'(tbl[i].pc));
            tick();
        end
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        for (int n = 0; n < 3000; n++) begin
            bit take, req;
            longint cand;
            rst = ($urandom_range(0, 299) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc = $urandom;
            stall = ($urandom_range(0, 5) == 0);
            credit_return = ($urandom_range(0, 2) == 0);
            pred_valid = $urandom_range(0, 1);
            pred_taken = $urandom_range(0, 1);
            pred_target = $urandom;
            @(negedge clk);
            m_eval(take, req, cand);
            chk($sformatf("rand%0d fetch_req", n), 64'(fetch_req), 64'(req));
            chk($sformatf("rand%0d fetch_pc", n), 64'(fetch_pc), 64'(cand));
            chk($sformatf("rand%0d fetch_epoch", n), 64'(fetch_epoch), 64'(m_ep));
            chk($sformatf("rand%0d btb_pc", n), 64'(btb_pc), 64'(cand));
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
